cte_rgb_writer: RTL

Downstream stage of the Color Transform Engine. It captures each 24-bit RGB pixel the engine presents with out_valid, buffers it in a small FIFO, and writes it to a frame memory port using a valid/ready handshake and an incrementing address. A start pulse arms one frame of FRAME_PIX pixels. The block pulses done when the last pixel has been written, and flags any pixel lost because the engine has no output backpressure.

---
 rtl/cte_rgb_writer.sv | 104 ++++++++++
 1 files changed

// File: rtl/cte_rgb_writer.sv
// Color Transform Engine output stage: buffers engine pixels in a small FIFO and
// writes one frame of FRAME_PIX pixels to memory at contiguous addresses.
module cte_rgb_writer #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 16,
    parameter int FRAME_PIX = 500,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              out_valid,
    input  logic [23:0]       rgb_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [ADDR_W:0]   FP   = (ADDR_W+1)'(FRAME_PIX);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [1:0]        state, state_nxt;
    logic [23:0]       mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [ADDR_W:0]   in_cnt, out_cnt, in_cnt_nxt, out_cnt_nxt;
    logic              active, empty, full, offer, push, pop, drop;

    assign active  = (state == S_RUN) || (state == S_DRAIN);
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));

    // Outputs come only from state, FIFO and counter registers; wr_ready never reaches them.
    assign wr_en   = active && !empty;
    assign wr_data = empty ? 24'd0 : mem[rd_ptr];
    assign wr_addr = BASE + out_cnt[ADDR_W-1:0];
    assign busy    = active;
    assign done    = (state == S_DONE);

    assign pop     = wr_en && wr_ready;
    assign offer   = (state == S_RUN) && out_valid && (in_cnt < FP);
    assign push    = offer && (!full || pop);
    assign drop    = offer && !push;

    assign in_cnt_nxt  = in_cnt  + {{ADDR_W{1'b0}}, push};
    assign out_cnt_nxt = out_cnt + {{ADDR_W{1'b0}}, pop};

    // Transitions look at next-cycle counts so done rises on the edge of the last write.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (out_cnt_nxt == FP)     state_nxt = S_DONE;
                else if (in_cnt_nxt == FP) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (out_cnt_nxt == FP) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                in_cnt   <= '0;
                out_cnt  <= '0;
                overflow <= 1'b0;
            end else begin
                in_cnt  <= in_cnt_nxt;
                out_cnt <= out_cnt_nxt;
                if (drop) overflow <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: wr_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rgb_out;
    end
endmodule
